// File: rtl/penc_norm_pipe_if.sv
// penc_norm_pipe_if
//   Handshake and data bundle for the pipelined priority encoder / normaliser.
//   The master drives the input word and the downstream ready. The slave (the
//   encoder) returns the input ready and the result fields.
//   Ports and signals:
//     In_valid / In_ready   input-side handshake
//     Din, Lsb_mode, In_tag input word, search direction, sideband tag
//     Out_valid / Out_ready output-side handshake
//     Dout, Valid, Shamt    winning bit index, any-bit-set flag, shift applied
//     Norm, Out_tag         normalised word and the tag of that word
interface penc_norm_pipe_if #(
  parameter int WIDTH = 32,
  parameter int IW    = 5,
  parameter int TAG_W = 4
);
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] Din;
  logic             Lsb_mode;
  logic [TAG_W-1:0] In_tag;
  logic             Out_valid;
  logic             Out_ready;
  logic [IW-1:0]    Dout;
  logic             Valid;
  logic [IW-1:0]    Shamt;
  logic [WIDTH-1:0] Norm;
  logic [TAG_W-1:0] Out_tag;

  modport master (
    output In_valid, Din, Lsb_mode, In_tag, Out_ready,
    input  In_ready, Out_valid, Dout, Valid, Shamt, Norm, Out_tag
  );

  modport slave (
    input  In_valid, Din, Lsb_mode, In_tag, Out_ready,
    output In_ready, Out_valid, Dout, Valid, Shamt, Norm, Out_tag
  );
endinterface

// File: rtl/penc_norm_pipe.sv
// penc_norm_pipe
//   Two-stage pipelined priority encoder with normaliser for the FP add/sub
//   datapath. Finds the highest (Lsb_mode=0) or lowest (Lsb_mode=1) set bit of
//   Din, reports its index on Dout and shifts the word so that bit lands at the
//   MSB (or LSB) on Norm. A sideband tag travels with each word.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous reset, active-high
//     bus  penc_norm_pipe_if slave view (handshakes, input word, results)
//   Stage 1 registers the word plus one 8-bit encoder result per byte group.
//   Stage 2 merges the group results and registers the final outputs.
module penc_norm_pipe #(
  parameter int WIDTH = 32,
  parameter int IW    = 5,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  penc_norm_pipe_if.slave  bus
);

  localparam int NG = WIDTH / 8;

  // Index of the highest (lsb=0) or lowest (lsb=1) set bit within one byte.
  // Returns 0 for an all-zero byte; the group valid bit qualifies it.
  function automatic logic [2:0] enc8(input logic [7:0] b, input logic lsb);
    logic [2:0] r;
    r = 3'd0;
    if (lsb) begin
      for (int i = 7; i >= 0; i--) begin
        if (b[i]) r = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (b[i]) r = 3'(i);
      end
    end
    return r;
  endfunction

  // Handshake
  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic adv1, adv2, in_ready;

  // Stage 1 contents
  logic [WIDTH-1:0]       din1_q, din1_d;
  logic                   lsb1_q, lsb1_d;
  logic [TAG_W-1:0]       tag1_q, tag1_d;
  logic [NG-1:0]          gv1_q, gv1_d;
  logic [NG-1:0][2:0]     gidx1_q, gidx1_d;

  // Stage 2 contents (the visible result)
  logic [IW-1:0]          dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic [IW-1:0]          shamt_q, shamt_d;
  logic [WIDTH-1:0]       norm_q, norm_d;
  logic [TAG_W-1:0]       otag_q, otag_d;

  // Stage 2 combinational merge
  int                     sel_g;
  logic [2:0]             sel_idx;
  logic                   any_v;
  logic [IW-1:0]          idx_c;
  logic [IW-1:0]          shamt_c;

  // Stage 2 can move when it holds nothing or its result leaves this cycle;
  // stage 1 can accept when it is empty or is emptying into stage 2.
  assign adv2     = v1_q & (~v2_q | bus.Out_ready);
  assign in_ready = ~v1_q | adv2;
  assign adv1     = bus.In_valid & in_ready;

  always_comb begin
    v1_d = v1_q;
    if (adv1) begin
      v1_d = 1'b1;
    end else if (adv2) begin
      v1_d = 1'b0;
    end
  end

  always_comb begin
    v2_d = v2_q;
    if (adv2) begin
      v2_d = 1'b1;
    end else if (bus.Out_ready) begin
      v2_d = 1'b0;
    end
  end

  always_comb begin
    din1_d  = din1_q;
    lsb1_d  = lsb1_q;
    tag1_d  = tag1_q;
    gv1_d   = gv1_q;
    gidx1_d = gidx1_q;
    if (adv1) begin
      din1_d = bus.Din;
      lsb1_d = bus.Lsb_mode;
      tag1_d = bus.In_tag;
      for (int g = 0; g < NG; g++) begin
        gv1_d[g]   = |bus.Din[g*8 +: 8];
        gidx1_d[g] = enc8(bus.Din[g*8 +: 8], bus.Lsb_mode);
      end
    end
  end

  // Group pick: the loop direction makes the last valid group visited win,
  // so ascending order finds the highest group and descending the lowest.
  always_comb begin
    sel_g   = 0;
    sel_idx = 3'd0;
    if (lsb1_q) begin
      for (int g = NG - 1; g >= 0; g--) begin
        if (gv1_q[g]) begin
          sel_g   = g;
          sel_idx = gidx1_q[g];
        end
      end
    end else begin
      for (int g = 0; g < NG; g++) begin
        if (gv1_q[g]) begin
          sel_g   = g;
          sel_idx = gidx1_q[g];
        end
      end
    end
  end

  always_comb begin
    any_v   = |gv1_q;
    idx_c   = IW'(sel_g * 8) | IW'(sel_idx);
    shamt_c = lsb1_q ? idx_c : (IW'(WIDTH - 1) - idx_c);
  end

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    shamt_d = shamt_q;
    norm_d  = norm_q;
    otag_d  = otag_q;
    if (adv2) begin
      otag_d  = tag1_q;
      valid_d = any_v;
      if (any_v) begin
        dout_d  = idx_c;
        shamt_d = shamt_c;
        norm_d  = lsb1_q ? (din1_q >> shamt_c) : (din1_q << shamt_c);
      end else begin
        dout_d  = '0;
        shamt_d = '0;
        norm_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      din1_q  <= '0;
      lsb1_q  <= 1'b0;
      tag1_q  <= '0;
      gv1_q   <= '0;
      gidx1_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      shamt_q <= '0;
      norm_q  <= '0;
      otag_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      din1_q  <= din1_d;
      lsb1_q  <= lsb1_d;
      tag1_q  <= tag1_d;
      gv1_q   <= gv1_d;
      gidx1_q <= gidx1_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      shamt_q <= shamt_d;
      norm_q  <= norm_d;
      otag_q  <= otag_d;
    end
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_valid = v2_q;
  assign bus.Dout      = dout_q;
  assign bus.Valid     = valid_q;
  assign bus.Shamt     = shamt_q;
  assign bus.Norm      = norm_q;
  assign bus.Out_tag   = otag_q;

endmodule

// File: tb/tb_penc_norm_pipe.sv
// tb_penc_norm_pipe
//   Directed bench for penc_norm_pipe at WIDTH=32, IW=5, TAG_W=4.
//   Inputs change and outputs are sampled around the falling edge.
module tb_penc_norm_pipe;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  int   pi;
  int   ci;
  int   last_c;
  int   b;

  penc_norm_pipe_if #(.WIDTH(32), .IW(5), .TAG_W(4)) bus ();

  penc_norm_pipe #(.WIDTH(32), .IW(5), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated word through an empty pipe with Out_ready held high.
  task automatic single(input string nm, input logic [31:0] din, input logic lsb,
                        input logic [3:0] tag, input logic [4:0] e_dout,
                        input logic e_valid, input logic [4:0] e_shamt,
                        input logic [31:0] e_norm);
    @(negedge clk);
    bus.In_valid  = 1'b1;
    bus.Din       = din;
    bus.Lsb_mode  = lsb;
    bus.In_tag    = tag;
    bus.Out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, bus.In_ready, 1);
    @(negedge clk);
    bus.In_valid = 1'b0;
    bus.Din      = 32'hDEAD_BEEF;
    #1;
    chk({nm, "_ov_early"}, bus.Out_valid, 0);
    @(negedge clk);
    #1;
    chk({nm, "_ov"},    bus.Out_valid, 1);
    chk({nm, "_dout"},  bus.Dout,      e_dout);
    chk({nm, "_valid"}, bus.Valid,     e_valid);
    chk({nm, "_shamt"}, bus.Shamt,     e_shamt);
    chk({nm, "_norm"},  bus.Norm,      e_norm);
    chk({nm, "_tag"},   bus.Out_tag,   tag);
    @(negedge clk);
    #1;
    chk({nm, "_ov_done"}, bus.Out_valid, 0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst           = 1'b1;
    bus.In_valid  = 1'b0;
    bus.Din       = '0;
    bus.Lsb_mode  = 1'b0;
    bus.In_tag    = '0;
    bus.Out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ov",    bus.Out_valid, 0);
    chk("rst_dout",  bus.Dout,      0);
    chk("rst_valid", bus.Valid,     0);
    chk("rst_shamt", bus.Shamt,     0);
    chk("rst_norm",  bus.Norm,      0);
    chk("rst_tag",   bus.Out_tag,   0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.In_ready, 1);

    single("t1_msb",     32'h0000_0100, 1'b0, 4'h1, 5'd8,  1'b1, 5'd23, 32'h8000_0000);
    single("t2_lsb",     32'h00F0_0000, 1'b1, 4'h2, 5'd20, 1'b1, 5'd20, 32'h0000_000F);
    single("t2_msb",     32'h00F0_0000, 1'b0, 4'h3, 5'd23, 1'b1, 5'd8,  32'hF000_0000);
    single("t3_zero",    32'h0000_0000, 1'b0, 4'hA, 5'd0,  1'b0, 5'd0,  32'h0000_0000);
    single("t6_top",     32'h8000_0000, 1'b0, 4'h4, 5'd31, 1'b1, 5'd0,  32'h8000_0000);
    single("t6_bot",     32'h0000_0001, 1'b0, 4'h5, 5'd0,  1'b1, 5'd31, 32'h8000_0000);
    single("t6_ones",    32'hFFFF_FFFF, 1'b1, 4'h6, 5'd0,  1'b1, 5'd0,  32'hFFFF_FFFF);
    single("grp_msb",    32'h0001_2300, 1'b0, 4'h7, 5'd16, 1'b1, 5'd15, 32'h9180_0000);
    single("grp_lsb",    32'h0001_2300, 1'b1, 4'h8, 5'd8,  1'b1, 5'd8,  32'h0000_0123);
    single("ends_lsb",   32'h8000_0001, 1'b1, 4'h9, 5'd0,  1'b1, 5'd0,  32'h8000_0001);

    // Stream of 8 single-bit words (bit 3*i+1), alternating modes, tags 0..7,
    // with Out_ready low on cycles 5..7. Word k is visible from cycle 2+k and
    // the stall pushes the last transfer out to cycle 12.
    pi     = 0;
    ci     = 0;
    last_c = -1;
    for (int c = 0; c < 60 && ci < 8; c++) begin
      @(negedge clk);
      bus.In_valid  = (pi < 8);
      bus.Din       = 32'h1 << ((pi * 3 + 1) % 32);
      bus.Lsb_mode  = pi[0];
      bus.In_tag    = pi[3:0];
      bus.Out_ready = !(c >= 5 && c < 8);
      #1;
      if (c == 6) chk("s_stall_in_ready", bus.In_ready, 0);
      if (bus.Out_valid) begin
        b = ci * 3 + 1;
        chk("s_tag",   bus.Out_tag, ci);
        chk("s_dout",  bus.Dout,    b);
        chk("s_valid", bus.Valid,   1);
        chk("s_shamt", bus.Shamt,   ci[0] ? b : 31 - b);
        chk("s_norm",  bus.Norm,    ci[0] ? 32'h1 : 32'h8000_0000);
        if (bus.Out_ready) begin
          ci++;
          last_c = c;
        end
      end
      if (bus.In_valid && bus.In_ready) pi++;
    end
    chk("s_count",      ci,     8);
    chk("s_last_cycle", last_c, 12);
    @(negedge clk);
    bus.In_valid = 1'b0;
    #1;
    chk("s_drained", bus.Out_valid, 0);

    // Reset with two words in flight.
    @(negedge clk);
    bus.In_valid  = 1'b1;
    bus.Din       = 32'h0000_0010;
    bus.Lsb_mode  = 1'b0;
    bus.In_tag    = 4'hC;
    bus.Out_ready = 1'b0;
    @(negedge clk);
    bus.In_tag    = 4'hD;
    @(negedge clk);
    bus.In_valid  = 1'b0;
    #1;
    chk("r_inflight_ov", bus.Out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("r_ov_cleared", bus.Out_valid, 0);
    chk("r_tag_cleared", bus.Out_tag, 0);
    rst = 1'b0;
    bus.Out_ready = 1'b1;
    #1;
    chk("r_in_ready", bus.In_ready, 1);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("r_no_ghost", bus.Out_valid, 0);
    end
    single("r_resume", 32'h0000_4000, 1'b1, 4'h5, 5'd14, 1'b1, 5'd14, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
